// File: rtl/transmitter_decode.sv
// Decode-stage transmitter: splits fetched words into opcode/register/immediate fields,
// merges a trailing long immediate, and drives a registered NOP bubble whenever no instruction is presented.
module transmitter_decode #(
    parameter int                  OPCODE_W   = 5,
    parameter int                  REG_W      = 4,
    parameter int                  DATA_W     = 32,
    parameter logic [OPCODE_W-1:0] NOP_OPCODE = '0
) (
    input  logic                clk_r,
    input  logic                reset_n_r,
    input  logic [DATA_W-1:0]   instr_in_d_t,
    input  logic                instr_valid_d_t,
    output logic                instr_ready_d_t,
    input  logic                flush_d_t,
    input  logic                ready_in_d_t,
    output logic [OPCODE_W-1:0] opcode_out_d_t,
    output logic [REG_W-1:0]    dest_out_d_t,
    output logic [REG_W-1:0]    s1_out_d_t,
    output logic [REG_W-1:0]    s2_out_d_t,
    output logic [DATA_W-1:0]   ime_data_out_d_t,
    output logic                valid_out_d_t
);

    localparam int OP_LSB   = DATA_W - OPCODE_W;
    localparam int DEST_LSB = OP_LSB - REG_W;
    localparam int S1_LSB   = DEST_LSB - REG_W;
    localparam int S2_LSB   = S1_LSB - REG_W;
    localparam int EXT_BIT  = S2_LSB - 1;
    localparam int SIMM_W   = EXT_BIT;

    typedef enum logic {S_INSTR, S_IMM} state_t;

    function automatic logic signed [DATA_W-1:0] sext_short(input logic [DATA_W-1:0] w);
        return {{(DATA_W-SIMM_W){w[SIMM_W-1]}}, w[SIMM_W-1:0]};
    endfunction

    state_t                     state;
    logic [OPCODE_W-1:0]        hold_op;
    logic [REG_W-1:0]           hold_dest;
    logic [REG_W-1:0]           hold_s1;
    logic [REG_W-1:0]           hold_s2;

    logic [OPCODE_W-1:0]        opcode_p1;
    logic [REG_W-1:0]           dest_p1;
    logic [REG_W-1:0]           s1_p1;
    logic [REG_W-1:0]           s2_p1;
    logic signed [DATA_W-1:0]   ime_p1;
    logic                       vld_p1;

    logic [OPCODE_W-1:0]        op_p0;
    logic [REG_W-1:0]           dest_p0;
    logic [REG_W-1:0]           s1_p0;
    logic [REG_W-1:0]           s2_p0;
    logic                       ext_p0;
    logic                       accept_p0;
    logic                       out_free;

    // Stage p0: field split of the word on the input bus
    assign op_p0   = instr_in_d_t[OP_LSB +: OPCODE_W];
    assign dest_p0 = instr_in_d_t[DEST_LSB +: REG_W];
    assign s1_p0   = instr_in_d_t[S1_LSB +: REG_W];
    assign s2_p0   = instr_in_d_t[S2_LSB +: REG_W];
    assign ext_p0  = instr_in_d_t[EXT_BIT];

    assign out_free        = !vld_p1 || ready_in_d_t;
    assign instr_ready_d_t = !flush_d_t && out_free;
    assign accept_p0       = instr_valid_d_t && instr_ready_d_t;

    // Stage p1: registered fields facing the decode pipeline register
    always_ff @(posedge clk_r or negedge reset_n_r) begin
        if (!reset_n_r) begin
            state     <= S_INSTR;
            hold_op   <= '0;
            hold_dest <= '0;
            hold_s1   <= '0;
            hold_s2   <= '0;
            opcode_p1 <= NOP_OPCODE;
            dest_p1   <= '0;
            s1_p1     <= '0;
            s2_p1     <= '0;
            ime_p1    <= '0;
            vld_p1    <= 1'b0;
        end else if (flush_d_t) begin
            state     <= S_INSTR;
            hold_op   <= '0;
            hold_dest <= '0;
            hold_s1   <= '0;
            hold_s2   <= '0;
            opcode_p1 <= NOP_OPCODE;
            dest_p1   <= '0;
            s1_p1     <= '0;
            s2_p1     <= '0;
            ime_p1    <= '0;
            vld_p1    <= 1'b0;
        end else if (out_free) begin
            if (accept_p0 && state == S_IMM) begin
                opcode_p1 <= hold_op;
                dest_p1   <= hold_dest;
                s1_p1     <= hold_s1;
                s2_p1     <= hold_s2;
                ime_p1    <= instr_in_d_t;
                vld_p1    <= 1'b1;
                state     <= S_INSTR;
            end else if (accept_p0 && !ext_p0) begin
                opcode_p1 <= op_p0;
                dest_p1   <= dest_p0;
                s1_p1     <= s1_p0;
                s2_p1     <= s2_p0;
                ime_p1    <= sext_short(instr_in_d_t);
                vld_p1    <= 1'b1;
            end else begin
                // Nothing completes: bubble, and park the header if it needs an immediate word
                opcode_p1 <= NOP_OPCODE;
                dest_p1   <= '0;
                s1_p1     <= '0;
                s2_p1     <= '0;
                ime_p1    <= '0;
                vld_p1    <= 1'b0;
                if (accept_p0) begin
                    hold_op   <= op_p0;
                    hold_dest <= dest_p0;
                    hold_s1   <= s1_p0;
                    hold_s2   <= s2_p0;
                    state     <= S_IMM;
                end
            end
        end
    end

    assign opcode_out_d_t   = opcode_p1;
    assign dest_out_d_t     = dest_p1;
    assign s1_out_d_t       = s1_p1;
    assign s2_out_d_t       = s2_p1;
    assign ime_data_out_d_t = ime_p1;
    assign valid_out_d_t    = vld_p1;

endmodule

// File: tb/tb_transmitter_decode.sv
// Bench for transmitter_decode: directed steps plus random traffic against a transaction-level model.
module tb_transmitter_decode;

    logic        clk_r = 1'b0;
    logic        reset_n_r = 1'b0;
    logic [31:0] instr_in_d_t = '0;
    logic        instr_valid_d_t = 1'b0;
    logic        instr_ready_d_t;
    logic        flush_d_t = 1'b0;
    logic        ready_in_d_t = 1'b1;
    logic [4:0]  opcode_out_d_t;
    logic [3:0]  dest_out_d_t;
    logic [3:0]  s1_out_d_t;
    logic [3:0]  s2_out_d_t;
    logic [31:0] ime_data_out_d_t;
    logic        valid_out_d_t;

    int errors = 0;
    int checks = 0;

    // Model: what the decode register should show, plus a header waiting for its immediate
    logic [31:0] m_op, m_dest, m_s1, m_s2, m_ime;
    logic        m_valid;
    logic        m_pend;
    logic [31:0] h_word;

    transmitter_decode dut (
        .clk_r            (clk_r),
        .reset_n_r        (reset_n_r),
        .instr_in_d_t     (instr_in_d_t),
        .instr_valid_d_t  (instr_valid_d_t),
        .instr_ready_d_t  (instr_ready_d_t),
        .flush_d_t        (flush_d_t),
        .ready_in_d_t     (ready_in_d_t),
        .opcode_out_d_t   (opcode_out_d_t),
        .dest_out_d_t     (dest_out_d_t),
        .s1_out_d_t       (s1_out_d_t),
        .s2_out_d_t       (s2_out_d_t),
        .ime_data_out_d_t (ime_data_out_d_t),
        .valid_out_d_t    (valid_out_d_t)
    );

    always #5 clk_r = ~clk_r;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_bubble();
        m_op = 0; m_dest = 0; m_s1 = 0; m_s2 = 0; m_ime = 0; m_valid = 1'b0;
    endtask

    task automatic model_reset();
        model_bubble();
        m_pend = 1'b0;
        h_word = 0;
    endtask

    // Header fields taken straight from the word layout
    task automatic model_emit(input logic [31:0] hdr, input logic [31:0] imm);
        m_op    = (hdr >> 27) & 32'h1f;
        m_dest  = (hdr >> 23) & 32'hf;
        m_s1    = (hdr >> 19) & 32'hf;
        m_s2    = (hdr >> 15) & 32'hf;
        m_ime   = imm;
        m_valid = 1'b1;
    endtask

    function automatic logic [31:0] short_imm(input logic [31:0] w);
        logic [31:0] v;
        v = w & 32'h3fff;
        if (v >= 32'h2000) v = v - 32'h4000;
        return v;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".opcode"}, 32'(opcode_out_d_t), m_op);
        check({tag, ".dest"}, 32'(dest_out_d_t), m_dest);
        check({tag, ".s1"}, 32'(s1_out_d_t), m_s1);
        check({tag, ".s2"}, 32'(s2_out_d_t), m_s2);
        check({tag, ".ime"}, ime_data_out_d_t, m_ime);
        check({tag, ".valid"}, 32'(valid_out_d_t), 32'(m_valid));
    endtask

    task automatic cycle(input string tag, input logic v, input logic [31:0] w,
                         input logic f, input logic r);
        logic exp_rdy;
        logic acc;
        @(negedge clk_r);
        instr_valid_d_t = v;
        instr_in_d_t    = w;
        flush_d_t       = f;
        ready_in_d_t    = r;
        #1;
        exp_rdy = !f && (!m_valid || r);
        check({tag, ".instr_ready"}, 32'(instr_ready_d_t), 32'(exp_rdy));
        acc = v && exp_rdy;
        @(posedge clk_r);
        if (f) begin
            model_reset();
        end else if (!(m_valid && !r)) begin
            if (acc && m_pend) begin
                model_emit(h_word, w);
                m_pend = 1'b0;
            end else if (acc && !w[14]) begin
                model_emit(w, short_imm(w));
            end else begin
                model_bubble();
                if (acc) begin
                    m_pend = 1'b1;
                    h_word = w;
                end
            end
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk_r);
        instr_valid_d_t = 1'b0;
        #2 reset_n_r = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        @(negedge clk_r);
        #1 reset_n_r = 1'b1;
    endtask

    initial begin
        int nvalid;
        logic [31:0] w;
        model_reset();

        // Reset state
        #3;
        check_outputs("reset");
        #20 reset_n_r = 1'b1;
        @(negedge clk_r);
        check_outputs("post_reset");
        check("post_reset.instr_ready", 32'(instr_ready_d_t), 32'd1);

        // Short immediate: ext=0, imm 0x3FFF -> all ones
        cycle("short", 1'b1, 32'h1A2BBFFF, 1'b0, 1'b1);
        check("short.ime_const", ime_data_out_d_t, 32'hFFFFFFFF);
        check("short.opcode_const", 32'(opcode_out_d_t), 32'h3);
        check("short.s2_const", 32'(s2_out_d_t), 32'h7);

        // Long immediate
        cycle("long_hdr", 1'b1, 32'h1A2BC000, 1'b0, 1'b1);
        check("long_hdr.valid_const", 32'(valid_out_d_t), 32'd0);
        cycle("long_imm", 1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
        check("long_imm.ime_const", ime_data_out_d_t, 32'hDEADBEEF);
        check("long_imm.dest_const", 32'(dest_out_d_t), 32'h4);

        // Backpressure for three clocks, then consume and accept together
        cycle("bp0", 1'b1, 32'h10812345, 1'b0, 1'b0);
        cycle("bp1", 1'b1, 32'h10812345, 1'b0, 1'b0);
        cycle("bp2", 1'b1, 32'h10812345, 1'b0, 1'b0);
        check("bp.ime_held", ime_data_out_d_t, 32'hDEADBEEF);
        cycle("bp_release", 1'b1, 32'h10812345, 1'b0, 1'b1);

        // Flush while waiting for an immediate
        cycle("fl_hdr", 1'b1, 32'h2AAAC000, 1'b0, 1'b1);
        cycle("flush", 1'b1, 32'h12345678, 1'b1, 1'b1);
        cycle("fl_next", 1'b1, 32'h08000005, 1'b0, 1'b1);
        check("fl_next.ime_const", ime_data_out_d_t, 32'h5);
        check("fl_next.opcode_const", 32'(opcode_out_d_t), 32'h1);

        // Back-to-back ext words: one valid output per two words
        nvalid = 0;
        for (int i = 0; i < 20; i++) begin
            w = $urandom;
            w[14] = 1'b1;
            cycle("ext_stream", 1'b1, w, 1'b0, 1'b1);
            if (valid_out_d_t) nvalid++;
        end
        check("ext_stream.valid_count", 32'(nvalid), 32'd10);

        // Async reset with a header pending
        w = $urandom;
        w[14] = 1'b1;
        cycle("pre_areset", 1'b1, w, 1'b0, 1'b1);
        async_reset("areset");
        cycle("post_areset", 1'b1, 32'h08000005, 1'b0, 1'b1);
        check("post_areset.valid_const", 32'(valid_out_d_t), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            w = $urandom;
            cycle("rand", ($urandom_range(0, 3) != 0), w,
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
